// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator with a pixel-clock divider, sync generation and a
// built-in pattern source. Sync and colour outputs lag the x/y counters by one pixel period.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int PIX_DIV    = 2,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] ext_rgb,
  output logic [XW-1:0]           x,
  output logic [YW-1:0]           y,
  output logic                    active,
  output logic                    pix_tick,
  output logic                    frame_start,
  output logic                    hsync,
  output logic                    vsync,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue
);

  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_EXT   = 2'd3;

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0
      || PIX_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: porch/sync widths must be non-zero and PIX_DIV >= 1");
  end

  // pix_tick is the single pixel strobe: every counter and output register advances only on it.
  if (PIX_DIV == 1) begin : g_no_div
    assign pix_tick = 1'b1;
  end else begin : g_div
    localparam int DW = $clog2(PIX_DIV);
    logic [DW-1:0] div;

    always_ff @(posedge clk) begin
      if (reset) begin
        div <= '0;
      end else if (div == DW'(PIX_DIV - 1)) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end

    assign pix_tick = (div == DW'(PIX_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (pix_tick) begin
      if (x == XW'(H_TOTAL - 1)) begin
        x <= '0;
        y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  logic h_sync_on;
  logic v_sync_on;

  assign active      = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign frame_start = pix_tick && (x == '0) && (y == '0);
  assign h_sync_on   = (x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync_on   = (y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC));

  // Checkerboard squares are 32 pixels; narrow counters never reach bit 5.
  logic x_bit5;
  logic y_bit5;

  if (XW > 5) begin : g_x5
    assign x_bit5 = x[5];
  end else begin : g_no_x5
    assign x_bit5 = 1'b0;
  end

  if (YW > 5) begin : g_y5
    assign y_bit5 = y[5];
  end else begin : g_no_y5
    assign y_bit5 = 1'b0;
  end

  // Bar index = floor(x*8/H_ACTIVE), found as the number of ceil(k*H_ACTIVE/8) thresholds passed.
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= XW'((k * H_ACTIVE + 7) / 8)) begin
        bar_idx = 3'(k);
      end
    end
  end

  // The pixel at (0,0) already uses the mode being latched on frame_start.
  logic [1:0] mode_q;
  logic [1:0] eff_mode;

  assign eff_mode = frame_start ? mode : mode_q;

  logic [COLOR_BITS-1:0] red_n;
  logic [COLOR_BITS-1:0] green_n;
  logic [COLOR_BITS-1:0] blue_n;

  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    if (active) begin
      case (eff_mode)
        MODE_BARS: begin
          // Bar order white, yellow, cyan, green, magenta, red, blue, black.
          red_n   = {COLOR_BITS{~bar_idx[1]}};
          green_n = {COLOR_BITS{~bar_idx[2]}};
          blue_n  = {COLOR_BITS{~bar_idx[0]}};
        end
        MODE_CHECK: begin
          red_n   = {COLOR_BITS{x_bit5 ^ y_bit5}};
          green_n = {COLOR_BITS{x_bit5 ^ y_bit5}};
          blue_n  = {COLOR_BITS{x_bit5 ^ y_bit5}};
        end
        MODE_EXT: begin
          {red_n, green_n, blue_n} = ext_rgb;
        end
        default: begin
          red_n   = '0;
          green_n = '0;
          blue_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync  <= ~HSYNC_POL;
      vsync  <= ~VSYNC_POL;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      mode_q <= mode;
    end else begin
      if (frame_start) begin
        mode_q <= mode;
      end
      if (pix_tick) begin
        hsync <= h_sync_on ? HSYNC_POL : ~HSYNC_POL;
        vsync <= v_sync_on ? VSYNC_POL : ~VSYNC_POL;
        red   <= red_n;
        green <= green_n;
        blue  <= blue_n;
      end
    end
  end

endmodule
